// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction-memory interface.
//
// Takes a host byte stream made of a header byte N (instruction count, 0 means 256)
// followed by 4*N instruction bytes. Each group of 4 bytes is packed little-endian
// into one 32-bit word {dest, arg2, arg1, opcode} and written to program RAM at
// consecutive addresses starting at START_ADDR. The CPU is held in reset
// (cpu_run = 0) until the load completes.
//
// Optional feature, macro PROGRAM_LOADER_CHECKSUM_EN: after the last word, one
// trailer byte is accepted. It must equal the XOR of the header and all
// instruction bytes. On a mismatch the loader parks in an error state, with error
// set and the CPU still held, until reload or rst. With the macro undefined,
// error is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   host byte valid
//   in_ready   loader can take a byte (combinational from state and reload)
//   in_data    host byte
//   reload     synchronous restart of the load sequence
//   mem_we     program RAM write strobe, one cycle per word
//   mem_addr   program RAM write address
//   mem_wdata  packed instruction word, opcode in [7:0]
//   cpu_run    0 holds the CPU in reset, 1 releases it
//   done       one-cycle pulse when the load completes
//   error      sticky checksum failure
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone,
    StCheck,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  // Nine bits so a header of 0 can stand for 256 instructions.
  logic [8:0]            remaining_q, remaining_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_run_q, done_q;
  logic                  accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  error_q;
`endif

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle, StLoad: in_ready = !reload;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck:        in_ready = !reload;
`endif
      default:        in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wdata_d     = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          remaining_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          idx_d       = 2'd0;
          state_d     = StLoad;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d      = in_data;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          wdata_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrite;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
        end
      end
      StWrite: begin
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 9'd1;
        if (remaining_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StLoad;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = (in_data == csum_q) ? StDone : StError;
      end
`endif
      default: ;
    endcase

    // Restart wins over everything else; partial words are discarded.
    if (reload && (state_q != StIdle)) begin
      state_d     = StIdle;
      idx_d       = 2'd0;
      addr_d      = StartAddr;
      remaining_d = 9'd0;
      wdata_d     = 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d      = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      addr_q      <= StartAddr;
      remaining_q <= 9'd0;
      wdata_q     <= 32'd0;
      cpu_run_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wdata_q     <= wdata_d;
      // Registered from next state so cpu_run is glitch-free and tracks StDone exactly.
      cpu_run_q   <= (state_d == StDone);
      done_q      <= (state_d == StDone) && (state_q != StDone);
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q  <= 8'd0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= (state_d == StError);
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = cpu_run_q;
  assign done      = done_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        reload;

  logic        in_ready, mem_we, cpu_run, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        in_ready_b, mem_we_b, cpu_run_b, done_b, error_b;
  logic [7:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .done(done), .error(error)
  );

  // Second instance sees the same stimulus; only its addresses are checked.
  program_loader #(.ADDR_WIDTH(8), .START_ADDR(254)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .reload(reload), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_run(cpu_run_b), .done(done_b), .error(error_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Write/done log, sampled on the falling edge.
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_addr_b[$];
  int          done_cnt = 0;
  int          run_bad = 0;
  int          ready_bad = 0;
  int          writes_at_done = -1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      if (in_ready) ready_bad++;
    end
    if (mem_we_b) wr_addr_b.push_back(int'(mem_addr_b));
    if (done) begin
      done_cnt++;
      writes_at_done = wr_addr.size();
      if (!cpu_run) run_bad++;
    end
  end

  function automatic int qa(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_addr_b.delete();
    done_cnt       = 0;
    run_bad        = 0;
    ready_bad      = 0;
    writes_at_done = -1;
  endtask

  logic [7:0] tb_csum;
  int         gap = 0;

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("send_timeout", {31'd0, got}, 32'd1);
    tb_csum = tb_csum ^ b;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    logic [7:0] trailer;
    tb_csum = 8'd0;
    foreach (s[i]) send_byte(s[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    trailer = tb_csum;
    send_byte(trailer);
`else
    trailer = 8'd0;
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int c = 0; c < limit && done_cnt == 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    clear_log();
  endtask

  task automatic check_basic(input string t);
    check({t, "_nwr"},  wr_addr.size(), 32'd2);
    check({t, "_a0"},   qa(wr_addr, 0), 32'd0);
    check({t, "_d0"},   qd(wr_data, 0), 32'h4433_2211);
    check({t, "_a1"},   qa(wr_addr, 1), 32'd1);
    check({t, "_d1"},   qd(wr_data, 1), 32'h8877_6655);
    check({t, "_done"}, done_cnt, 32'd1);
  endtask

  initial begin
    logic [7:0] s[$];
    int bad;

    rst = 1'b0; in_valid = 1'b0; in_data = 8'd0; reload = 1'b0;
    #12;
    check("rst_we",    {31'd0, mem_we},  32'd0);
    check("rst_wdata", mem_wdata,        32'd0);
    check("rst_addr",  {24'd0, mem_addr}, 32'd0);
    check("rst_run",   {31'd0, cpu_run}, 32'd0);
    check("rst_done",  {31'd0, done},    32'd0);
    check("rst_err",   {31'd0, error},   32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic load, in_valid held high
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_stream(s);
    wait_done(60);
    check_basic("t1");
    check("t1_run_at_done", run_bad, 32'd0);
    check("t1_ready_in_write", ready_bad, 32'd0);
    check("t1_done_after_writes", writes_at_done, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("t1_run_stays", {31'd0, cpu_run}, 32'd1);
    check("t1_ready_done", {31'd0, in_ready}, 32'd0);
    check("t1_err", {31'd0, error}, 32'd0);
    check("t1_done_once", done_cnt, 32'd1);

    // 2: idle gaps between bytes
    pulse_reload();
    check("t2_run_cleared", {31'd0, cpu_run}, 32'd0);
    gap = 1;
    send_stream(s);
    gap = 0;
    wait_done(60);
    check_basic("t2");

    // 3: N = 0 means 256 words; address wraps afterwards
    pulse_reload();
    s.delete();
    s.push_back(8'h00);
    for (int k = 0; k < 1024; k++) s.push_back(8'(k));
    send_stream(s);
    wait_done(200);
    check("t3_nwr", wr_addr.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (qa(wr_addr, i) != i) bad++;
    check("t3_addr_seq", bad, 32'd0);
    check("t3_d0", qd(wr_data, 0), 32'h0302_0100);
    check("t3_d255", qd(wr_data, 255), 32'hFFFE_FDFC);
    check("t3_done_after_255", writes_at_done, 32'd256);
    check("t3_done", done_cnt, 32'd1);
    check("t3_addr_wrap", {24'd0, mem_addr}, 32'd0);

    // 3b: START_ADDR = 254, N = 3
    pulse_reload();
    s = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
          8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_stream(s);
    wait_done(60);
    check("t3b_nwr", wr_addr_b.size(), 32'd3);
    check("t3b_a0", qa(wr_addr_b, 0), 32'd254);
    check("t3b_a1", qa(wr_addr_b, 1), 32'd255);
    check("t3b_a2", qa(wr_addr_b, 2), 32'd0);

    // 4: reload mid-instruction with a byte on offer
    pulse_reload();
    tb_csum = 8'd0;
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h99;
    reload   = 1'b1;
    @(negedge clk);
    check("t4_ready_on_reload", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_no_write", wr_addr.size(), 32'd0);
    check("t4_idle_ready", {31'd0, in_ready}, 32'd1);
    s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s);
    wait_done(60);
    check("t4_nwr", wr_addr.size(), 32'd1);
    check("t4_a0", qa(wr_addr, 0), 32'd0);
    check("t4_d0", qd(wr_data, 0), 32'hDDCC_BBAA);

    // 5: async reset mid-LOAD, then from DONE
    pulse_reload();
    tb_csum = 8'd0;
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (s[i]) send_byte(s[i]);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5_we", {31'd0, mem_we}, 32'd0);
    check("t5_addr", {24'd0, mem_addr}, 32'd0);
    check("t5_wdata", mem_wdata, 32'd0);
    check("t5_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst = 1'b1;
    clear_log();
    @(posedge clk);
    #1;
    s = '{8'h01, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    send_stream(s);
    wait_done(60);
    check("t5_d0", qd(wr_data, 0), 32'hD0C0_B0A0);
    check("t5_a0", qa(wr_addr, 0), 32'd0);
    check("t5_run_before", {31'd0, cpu_run}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_run_drop", {31'd0, cpu_run}, 32'd0);
    check("t5_done_drop", {31'd0, done}, 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_idle_ready", {31'd0, in_ready}, 32'd1);
    clear_log();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 6: trailer checksum, good then bad
    s = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    tb_csum = 8'd0;
    foreach (s[i]) send_byte(s[i]);
    send_byte(8'h05);
    in_valid = 1'b0;
    wait_done(60);
    check("t6_done", done_cnt, 32'd1);
    check("t6_run", {31'd0, cpu_run}, 32'd1);
    check("t6_err_ok", {31'd0, error}, 32'd0);
    pulse_reload();
    foreach (s[i]) send_byte(s[i]);
    send_byte(8'h00);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_err", {31'd0, error}, 32'd1);
    check("t6_err_run", {31'd0, cpu_run}, 32'd0);
    check("t6_err_nodone", done_cnt, 32'd0);
    check("t6_err_ready", {31'd0, in_ready}, 32'd0);
    pulse_reload();
    check("t6_err_clear", {31'd0, error}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's instruction-memory interface. The CPU core fetches one 4-byte instruction per 8-bit address: opcode, arg1 select, arg2 select, destination select.
- This block receives a host byte stream, packs each group of 4 bytes into one 32-bit instruction word, and writes the words to program RAM at consecutive addresses.
- It holds the CPU in reset while loading and releases it when the load completes.
- It sits between the host byte link and the program RAM write port / CPU reset.

Parameters:
- ADDR_WIDTH, 8: program address width. Matches the CPU's 8-bit counter.
- START_ADDR, 0: address of the first instruction written.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  host byte.
- reload  in  1  synchronous request to restart the load sequence.
- mem_we  out  1  program RAM write strobe, 1 cycle.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  32  instruction word {dest, arg2, arg1, opcode}. Opcode is in [7:0]; it is the first byte received.
- cpu_run  out  1  0 = CPU held in reset; 1 = CPU released.
- done  out  1  1-cycle pulse when the load completes.
- error  out  1  sticky checksum failure; see Optional Feature.

Behaviour:
- Handshake: a byte transfers on a clk edge where in_valid && in_ready. in_data is sampled only on that edge.
- in_ready = (state is IDLE or LOAD) && !reload. It is combinational from state and reload.
- States:
  - IDLE: waiting for the header byte.
  - LOAD: collecting instruction bytes.
  - WRITE: one cycle driving the RAM write.
  - DONE: load complete, CPU running.
- Reset (rst = 0), asynchronous:
  - state = IDLE; byte index = 0; addr = START_ADDR; remaining count = 0.
  - Outputs: mem_we = 0, mem_wdata = 0, cpu_run = 0, done = 0, error = 0.
- IDLE:
  - Accepted byte = N, the instruction count. N = 0 means 256.
  - Store N; go to LOAD.
- LOAD:
  - Each accepted byte goes to lane idx (0 to 3); idx then increments.
  - On acceptance with idx = 3: go to WRITE; idx = 0.
  - The host may hold in_valid low between bytes for any number of cycles; the byte count is unaffected.
- WRITE:
  - mem_we = 1 with the registered mem_addr and mem_wdata. in_ready = 0.
  - Next cycle: addr = addr + 1, modulo 2^ADDR_WIDTH (wraps 255 -> 0); remaining = remaining - 1.
  - If remaining reaches 0, go to DONE; otherwise go to LOAD.
  - Throughput: at best 5 cycles per instruction.
- DONE:
  - done pulses in the first DONE cycle only.
  - cpu_run = 1 from the first DONE cycle onward; it is registered, with no glitch.
  - Bytes are not accepted (in_ready = 0).
- cpu_run is 0 in every state except DONE.
- reload = 1 in any state except IDLE:
  - Next state = IDLE; idx = 0; addr = START_ADDR; partial bytes are discarded; cpu_run = 0 next cycle; error clears.
  - A byte presented in the same cycle is not accepted, because in_ready is forced to 0.
- reload in IDLE: no state change; in_ready = 0 that cycle.
- Reset asserted mid-load: immediate return to reset values; no further mem_we.
- mem_we never asserts outside WRITE.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the loader enters a CHECK state with in_ready = 1 and accepts one trailer byte.
  - Expected trailer = XOR of the header byte and all 4N instruction bytes.
  - Match: go to DONE as normal.
  - Mismatch: go to ERROR. In ERROR, error = 1, cpu_run = 0, done never pulses, in_ready = 0. Only reload or rst leaves ERROR.
- Not defined: no CHECK or ERROR states; after the last WRITE the loader goes directly to DONE; error is tied to 0.

Test Plan:
1. Basic load, after reset. Bytes 02, 11 22 33 44, 55 66 77 88 (host link held at in_valid = 1 throughout).
   - Required: mem_we at addr 0 with 0x44332211, then addr 1 with 0x88776655.
   - done pulses once; cpu_run = 1 the same cycle and stays 1.
   - in_ready is low in each WRITE cycle.
2. Backpressure and idle gaps. Same stream with in_valid toggled 1/0 every cycle.
   - Required: identical writes; every byte counted exactly once.
3. N = 0 (256 instructions) with START_ADDR = 0.
   - Required: 256 writes, addresses 0 to 255; done after the write at 255; address wraps to 0.
   - Repeat with START_ADDR = 254 and N = 3: writes at 254, 255, 0.
4. Reload mid-instruction. Header 02, bytes 11 22, then reload = 1 with in_valid = 1 and data 99.
   - Required: 99 not accepted; no mem_we.
   - A fresh stream 01 AA BB CC DD then writes 0xDDCCBBAA at addr 0.
5. Async reset. Assert rst = 0 mid-LOAD, between clock edges.
   - Required: cpu_run, mem_we and done drop immediately; after release the loader is in IDLE with in_ready = 1.
6. With PROGRAM_LOADER_CHECKSUM_EN. Stream 01 01 02 03 04 plus trailer.
   - Trailer 05 (= 01^01^02^03^04): done pulses and cpu_run = 1.
   - Trailer 00: error = 1 and cpu_run = 0 until reload.
